// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the logic-unit arbiter: opcode encodings and the
// result-register state type.
package logic_unit_arbiter_pkg;

  typedef logic [1:0] lop_t;

  localparam lop_t LOP_AND = 2'b00;
  localparam lop_t LOP_OR  = 2'b01;
  localparam lop_t LOP_XOR = 2'b10;
  localparam lop_t LOP_NOR = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam int BUSY_W = 16;

endpackage

// File: rtl/logic_unit_arbiter_rr_arbiter.sv
// Round-robin priority search: first set request at or after rr_ptr, wrapping.
// The encoded winner is always produced; the one-hot grant is gated by enable.
module logic_unit_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  logic [ID_W-1:0] cand;
  logic            found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    grant_any = found;
    if (found && enable) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// One shared 32-bit AND/OR/XOR/NOR unit, round-robin shared between NUM_REQ
// requesters, with a one-entry tagged result register on the output.
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [2*NUM_REQ-1:0]      req_op,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic [BUSY_W-1:0]         busy_cnt
);

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   rsp_data_reg, rsp_data_next;
  logic [ID_W-1:0]     rsp_id_reg, rsp_id_next;
  logic [ID_W-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [BUSY_W-1:0]   busy_cnt_reg, busy_cnt_next;

  lop_t                op_arr [NUM_REQ];
  logic [DATA_W-1:0]   a_arr  [NUM_REQ];
  logic [DATA_W-1:0]   b_arr  [NUM_REQ];

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_any;
  logic                slot_free;
  logic                accept;
  logic [DATA_W-1:0]   lop_result;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign op_arr[gi] = req_op[2*gi +: 2];
      assign a_arr[gi]  = req_a[DATA_W*gi +: DATA_W];
      assign b_arr[gi]  = req_b[DATA_W*gi +: DATA_W];
    end
  endgenerate

  // A held result frees its slot in the same cycle it is drained.
  assign slot_free = (state_reg == ST_EMPTY) | rsp_ready;

  logic_unit_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_reg),
    .enable    (slot_free),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = grant;
  assign accept    = grant_any & slot_free;

  always_comb begin
    lop_result = '0;
    case (op_arr[grant_idx])
      LOP_AND: lop_result = a_arr[grant_idx] & b_arr[grant_idx];
      LOP_OR:  lop_result = a_arr[grant_idx] | b_arr[grant_idx];
      LOP_XOR: lop_result = a_arr[grant_idx] ^ b_arr[grant_idx];
      LOP_NOR: lop_result = ~(a_arr[grant_idx] | b_arr[grant_idx]);
      default: lop_result = '0;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    rsp_data_next = rsp_data_reg;
    rsp_id_next   = rsp_id_reg;
    rr_ptr_next   = rr_ptr_reg;
    busy_cnt_next = busy_cnt_reg;
    if (accept) begin
      state_next    = ST_FULL;
      rsp_data_next = lop_result;
      rsp_id_next   = grant_idx;
      rr_ptr_next   = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
    end else if ((state_reg == ST_FULL) && rsp_ready) begin
      state_next = ST_EMPTY;
    end
    if ((|req_valid) && !accept && (busy_cnt_reg != {BUSY_W{1'b1}})) begin
      busy_cnt_next = busy_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_EMPTY;
      rsp_data_reg <= '0;
      rsp_id_reg   <= '0;
      rr_ptr_reg   <= '0;
      busy_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      rsp_data_reg <= rsp_data_next;
      rsp_id_reg   <= rsp_id_next;
      rr_ptr_reg   <= rr_ptr_next;
      busy_cnt_reg <= busy_cnt_next;
    end
  end

  assign rsp_valid = (state_reg == ST_FULL);
  assign rsp_data  = rsp_data_reg;
  assign rsp_id    = rsp_id_reg;
  assign busy_cnt  = busy_cnt_reg;

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one 32-bit logic unit (AND/OR/XOR/NOR) between NUM_REQ requesters.
- Requesters are typically the ALU issue path, the branch-compare path and the debug/test port.
- Round-robin arbitration picks one request. The operation is performed on the shared unit and the result is held in a one-entry output register, tagged with the requester id, until the consumer accepts it.
- Sits between the operand-fetch stage and the writeback mux.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of the requester id; must equal ceil(log2(NUM_REQ))
DATA_W, 32, operand/result width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
req_op  input  2*NUM_REQ  per-requester opcode, slice i = [2i+1:2i]; 00 AND, 01 OR, 10 XOR, 11 NOR
req_a  input  DATA_W*NUM_REQ  per-requester operand A, slice i = [DATA_W*i +: DATA_W]
req_b  input  DATA_W*NUM_REQ  per-requester operand B, same slicing
rsp_valid  output  1  result register holds a valid result
rsp_ready  input  1  consumer accepts result
rsp_data  output  DATA_W  result
rsp_id  output  ID_W  index of the requester that issued the result
busy_cnt  output  16  saturating count of cycles where a request was stalled

Behaviour:
- Clock and reset: single clock domain. rst_n is asynchronous assert, synchronous deassert (external synchroniser).
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=0, busy_cnt=0, state=EMPTY.
- State machine:
  - EMPTY: no result held.
  - FULL: result held, rsp_valid=1.
- Slot free: slot_free = (state==EMPTY) | (rsp_valid & rsp_ready).
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first set bit is the winner g.
  - req_ready[g] = slot_free; all other req_ready bits are 0.
  - If no req_valid is set, req_ready = 0.
  - req_ready never depends on req_op, req_a or req_b.
- Accept:
  - An accept is req_valid[g] & req_ready[g].
  - At that edge: rsp_data <= f(req_op[g], req_a[g], req_b[g]), rsp_id <= g, state <= FULL, rr_ptr <= (g+1) mod NUM_REQ.
  - Latency is 1 cycle: the result is visible the cycle after the accept.
- Drain:
  - rsp_valid & rsp_ready with no accept in the same cycle: state <= EMPTY; rsp_data and rsp_id hold their last value.
  - Simultaneous drain and accept: the new result replaces the old one and state stays FULL. This gives back-to-back throughput of 1 op/cycle.
- Backpressure: while FULL and rsp_ready=0:
  - req_ready=0.
  - rsp_data, rsp_id and rsp_valid are held stable.
  - rr_ptr does not move.
- Fairness: rr_ptr moves only on an accept. Any continuously asserted requester is granted within NUM_REQ accepts.
- Requester rule: a requester must hold req_valid and its operands stable until accepted. The arbiter does not check this.
- Opcode function f: AND=a&b, OR=a|b, XOR=a^b, NOR=~(a|b). Full DATA_W width, no carry, no flags.
- busy_cnt: increments when some req_valid=1 but no accept occurs that cycle. It saturates at 16'hFFFF and is cleared only by reset.
- Reset mid-operation: the held result is discarded, rsp_valid drops asynchronously and rr_ptr returns to 0.
- Idle: with no requests, state and outputs are unchanged and rr_ptr holds.

Decomposition:
- Shared package:
  - Opcode constants LOP_AND=2'b00, LOP_OR=2'b01, LOP_XOR=2'b10, LOP_NOR=2'b11.
  - A 2-bit logic-op typedef.
- One natural sub-module: rr_arbiter (parameterised NUM_REQ).
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: one-hot grant and encoded index.
- The logic function is a small combinational case statement in the top level, reusing the team's existing 32-bit logic operators.

Test Plan:
- Reset: rst_n=0 mid-FULL with rsp_data=32'hDEADBEEF -> rsp_valid=0 and rsp_data=0 immediately; after release, req_ready all 0 with no requests.
- Single XOR: requester 2 presents op=10, a=32'hFFFF0000, b=32'h0F0F0F0F, rsp_ready=1 -> req_ready=4'b0100 that cycle; next cycle rsp_valid=1, rsp_data=32'hF0F00F0F, rsp_id=2.
- Round-robin: all four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; one result per cycle; rsp_id sequence 0,1,2,3,0.
- Backpressure: FULL with NOR result of a=0, b=0 (32'hFFFFFFFF), rsp_ready=0 for 5 cycles while requester 1 is valid -> req_ready=0, output stable, busy_cnt increments by 5; on rsp_ready=1 requester 1 is accepted the same cycle.
- Wrap/ptr: rr_ptr=3, requests on 0 and 3 -> 3 granted first, then 0; rr_ptr ends at 1.
- Opcode sweep: AND, OR, XOR and NOR on random 32-bit operands -> rsp_data matches the reference model for 1000 random transactions with random rsp_ready.
